// File: rtl/float_argmin_stream.sv
// Streaming float argmin over tlast-delimited frames of {value, index} beats.
// One beat per cycle; one registered result per frame with a saturating beat count.
module float_argmin_stream #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [1+EXP_W+MAN_W+IDX_W-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [1+EXP_W+MAN_W+IDX_W-1:0] m_axis_result_tdata,
    output logic [CNT_W-1:0]               m_axis_result_tuser,
    output logic                           m_axis_result_tvalid,
    input  logic                           m_axis_result_tready
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int DW = FW + IDX_W;

    // Total order: NaN above everything, +0 == -0, sign-magnitude otherwise.
    function automatic logic f_less(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic          a_nan;
        logic          b_nan;
        logic [FW-2:0] a_mag;
        logic [FW-2:0] b_mag;
        a_mag = a[FW-2:0];
        b_mag = b[FW-2:0];
        a_nan = (&a[FW-2:MAN_W]) && (|a[MAN_W-1:0]);
        b_nan = (&b[FW-2:MAN_W]) && (|b[MAN_W-1:0]);
        if (a_nan)
            f_less = 1'b0;
        else if (b_nan)
            f_less = 1'b1;
        else if (a_mag == '0 && b_mag == '0)
            f_less = 1'b0;
        else if (a[FW-1] != b[FW-1])
            f_less = a[FW-1];
        else if (a[FW-1])
            f_less = a_mag > b_mag;
        else
            f_less = a_mag < b_mag;
        return f_less;
    endfunction

    logic [FW-1:0]    r_best_val;
    logic [IDX_W-1:0] r_best_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_have;
    logic [DW-1:0]    r_out_data;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_take;
    logic [FW-1:0]    w_beat_val;
    logic [IDX_W-1:0] w_beat_idx;
    logic [FW-1:0]    w_next_val;
    logic [IDX_W-1:0] w_next_idx;
    logic [CNT_W-1:0] w_next_cnt;

    assign s_axis_tready = !r_out_valid || m_axis_result_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign w_beat_val = s_axis_tdata[DW-1:IDX_W];
    assign w_beat_idx = s_axis_tdata[IDX_W-1:0];
    assign w_take     = !r_have || f_less(w_beat_val, r_best_val);
    assign w_next_val = w_take ? w_beat_val : r_best_val;
    assign w_next_idx = w_take ? w_beat_idx : r_best_idx;
    assign w_next_cnt = (&r_count) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_count     <= '0;
            r_have      <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept && s_axis_tlast) begin
                r_out_data  <= {w_next_val, w_next_idx};
                r_out_cnt   <= w_next_cnt;
                r_out_valid <= 1'b1;
                r_have      <= 1'b0;
                r_count     <= '0;
            end else begin
                if (m_axis_result_tready)
                    r_out_valid <= 1'b0;
                if (w_accept) begin
                    r_best_val <= w_next_val;
                    r_best_idx <= w_next_idx;
                    r_count    <= w_next_cnt;
                    r_have     <= 1'b1;
                end
            end
        end
    end

    assign m_axis_result_tdata  = r_out_data;
    assign m_axis_result_tuser  = r_out_cnt;
    assign m_axis_result_tvalid = r_out_valid;

endmodule

// File: tb/tb_float_argmin_stream.sv
// Directed bench for float_argmin_stream (FP32 values, 4-bit tags, 4-bit count).
// Results are also captured on every output handshake for ordering checks.
module tb_float_argmin_stream;

    localparam int CNT_W = 4;
    localparam int DW    = 36;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [DW-1:0]    s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             s_tlast = 1'b0;
    logic [DW-1:0]    r_tdata;
    logic [CNT_W-1:0] r_tuser;
    logic             r_tvalid;
    logic             r_tready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+CNT_W-1:0] res_q[$];
    time                 res_t[$];
    bit                  stall_seen = 1'b0;
    bit                  watch_stall = 1'b0;

    float_argmin_stream #(
        .EXP_W(8), .MAN_W(23), .IDX_W(4), .CNT_W(CNT_W)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_tdata         (s_tdata),
        .s_axis_tvalid        (s_tvalid),
        .s_axis_tready        (s_tready),
        .s_axis_tlast         (s_tlast),
        .m_axis_result_tdata  (r_tdata),
        .m_axis_result_tuser  (r_tuser),
        .m_axis_result_tvalid (r_tvalid),
        .m_axis_result_tready (r_tready)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (r_tvalid && r_tready) begin
            res_q.push_back({r_tuser, r_tdata});
            res_t.push_back($time);
        end
        if (watch_stall && s_tvalid && !s_tready)
            stall_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send(input logic [31:0] v, input logic [3:0] idx, input bit last);
        int n = 0;
        s_tdata  = {v, idx};
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50)
            check("send_timeout", 64'd0, 64'd1);
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] v,
                                 input logic [3:0] idx, input logic [3:0] cnt);
        check({tag, "_valid"}, 64'(r_tvalid), 64'd1);
        check({tag, "_data"},  64'(r_tdata),  64'({v, idx}));
        check({tag, "_user"},  64'(r_tuser),  64'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        #12;
        check("rst_valid", 64'(r_tvalid), 64'd0);
        check("rst_data",  64'(r_tdata),  64'd0);
        check("rst_user",  64'(r_tuser),  64'd0);
        check("rst_sready", 64'(s_tready), 64'd1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        send(32'h40000000, 4'd0, 1'b0);
        send(32'h3F800000, 4'd1, 1'b0);
        send(32'hBF800000, 4'd2, 1'b0);
        check("f1_not_early", 64'(r_tvalid), 64'd0);
        send(32'h40400000, 4'd3, 1'b1);
        expect_result("f1", 32'hBF800000, 4'd2, 4'd4);
        @(negedge aclk);
        check("f1_one_cycle", 64'(r_tvalid), 64'd0);

        send(32'h00000000, 4'd5, 1'b0);
        send(32'h80000000, 4'd6, 1'b0);
        send(32'h00000000, 4'd7, 1'b1);
        expect_result("zero_tie", 32'h00000000, 4'd5, 4'd3);

        send(32'h7FC00000, 4'd1, 1'b0);
        send(32'h7F800000, 4'd2, 1'b1);
        expect_result("nan_inf", 32'h7F800000, 4'd2, 4'd2);

        send(32'h7FC00001, 4'd3, 1'b0);
        send(32'h7FC00000, 4'd4, 1'b1);
        expect_result("all_nan", 32'h7FC00001, 4'd3, 4'd2);
        @(negedge aclk);

        // Backpressure: second single-beat frame must wait for the first result.
        res_q.delete();
        res_t.delete();
        r_tready = 1'b0;
        send(32'h3F800000, 4'd1, 1'b1);
        s_tdata  = {32'h40000000, 4'd2};
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_sready_low", 64'(s_tready), 64'd0);
            check("bp_hold_data", 64'(r_tdata), 64'({32'h3F800000, 4'd1}));
            check("bp_hold_valid", 64'(r_tvalid), 64'd1);
        end
        r_tready = 1'b1;
        #1;
        check("bp_sready_rise", 64'(s_tready), 64'd1);
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        expect_result("bp_second", 32'h40000000, 4'd2, 4'd1);
        @(negedge aclk);
        check("bp_drained", 64'(r_tvalid), 64'd0);
        check("bp_count", 64'(res_q.size()), 64'd2);
        if (res_q.size() == 2) begin
            check("bp_first",  64'(res_q[0]), 64'({4'd1, 32'h3F800000, 4'd1}));
            check("bp_second_q", 64'(res_q[1]), 64'({4'd1, 32'h40000000, 4'd2}));
        end

        // Streaming: three 4-beat frames back to back.
        res_q.delete();
        res_t.delete();
        stall_seen  = 1'b0;
        watch_stall = 1'b1;
        t0 = $time + 5;
        send(32'h40A00000, 4'd0, 1'b0);
        send(32'hC0000000, 4'd1, 1'b0);
        send(32'h3F000000, 4'd2, 1'b0);
        send(32'hC0400000, 4'd3, 1'b1);
        send(32'hFF800000, 4'd4, 1'b0);
        send(32'hBF800000, 4'd5, 1'b0);
        send(32'hFF800000, 4'd6, 1'b0);
        send(32'h7F800000, 4'd7, 1'b1);
        send(32'h00000001, 4'd8, 1'b0);
        send(32'h80000001, 4'd9, 1'b0);
        send(32'h00000000, 4'd10, 1'b0);
        send(32'h3F800000, 4'd11, 1'b1);
        @(negedge aclk);
        watch_stall = 1'b0;
        check("st_no_stall", 64'(stall_seen), 64'd0);
        check("st_count", 64'(res_q.size()), 64'd3);
        if (res_q.size() == 3) begin
            check("st_r0", 64'(res_q[0]), 64'({4'd4, 32'hC0400000, 4'd3}));
            check("st_r1", 64'(res_q[1]), 64'({4'd4, 32'hFF800000, 4'd4}));
            check("st_r2", 64'(res_q[2]), 64'({4'd4, 32'h80000001, 4'd9}));
            check("st_t0", 64'(res_t[0] - t0), 64'd40);
            check("st_t1", 64'(res_t[1] - t0), 64'd80);
            check("st_t2", 64'(res_t[2] - t0), 64'd120);
        end

        // Mid-frame asynchronous reset with a stale result still in the output register.
        send(32'h3F800000, 4'd1, 1'b0);
        send(32'hBF800000, 4'd2, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_valid", 64'(r_tvalid), 64'd0);
        check("ar_data",  64'(r_tdata),  64'd0);
        check("ar_user",  64'(r_tuser),  64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        send(32'h41200000, 4'd9, 1'b1);
        expect_result("after_rst", 32'h41200000, 4'd9, 4'd1);

        // Saturation: 20 beats, minimum at beat 17 (tag 1).
        for (int k = 1; k <= 20; k++) begin
            logic [31:0] v;
            v = (k == 17) ? 32'hC1000000 : (32'h40000000 + (32'(k) << 16));
            send(v, 4'(k), k == 20);
        end
        expect_result("sat", 32'hC1000000, 4'd1, 4'd15);
        @(negedge aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
